scoreboard_hazard_unit: RTL and testbench

- Parametrised successor to the single load-use STALL unit of the 5-stage pipeline.
- Keeps a per-register scoreboard (busy bit plus countdown of remaining stall cycles). From it, generates stall, bypass-select and WAW-ordering decisions for the instruction in ID.
- Supports variable-latency producers (ALU, load, multi-cycle units) up to MAXLAT cycles.
- Also provides a flush input and a saturating stall-cycle performance counter.
- Sits beside ID_STAGE. Its stall output gates PC/IF_ID update and zeroes wreg/wmem into ID_EXE.

---
 rtl/scoreboard_hazard_unit.sv | 98 +++++++++
 tb/tb_scoreboard_hazard_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_hazard_unit.sv
// Per-register scoreboard hazard unit: busy bit plus remaining-stall countdown per register,
// producing stall/issue/bypass decisions for the ID instruction and a saturating stall counter.
module scoreboard_hazard_unit #(
    parameter int unsigned AW     = 5,
    parameter int unsigned MAXLAT = 4,
    parameter int unsigned LW     = 3,
    parameter int unsigned CW     = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          id_valid_i,
    input  logic [AW-1:0] id_rs_i,
    input  logic [AW-1:0] id_rt_i,
    input  logic          id_use_rs_i,
    input  logic          id_use_rt_i,
    input  logic          id_wreg_i,
    input  logic [AW-1:0] id_rn_i,
    input  logic [LW-1:0] id_lat_i,
    input  logic          flush_i,
    input  logic          wb_wreg_i,
    input  logic [AW-1:0] wb_rn_i,
    output logic          stall_o,
    output logic          issue_o,
    output logic          fwd_rs_o,
    output logic          fwd_rt_o,
    output logic [CW-1:0] stall_cnt_o
);

    localparam int unsigned NREG = 2**AW;

    logic [NREG-1:0] busy_q, busy_d;
    logic [LW-1:0]   cnt_q [NREG];
    logic [LW-1:0]   cnt_d [NREG];
    logic [CW-1:0]   stall_cnt_q, stall_cnt_d;

    logic [LW-1:0] lat_c;
    logic          rs_tracked, rt_tracked, rn_tracked;
    logic          raw_rs, raw_rt, waw;

    assign lat_c = (id_lat_i > LW'(MAXLAT)) ? LW'(MAXLAT) : id_lat_i;

    // Register 0 is never tracked, so every lookup is gated on a non-zero index.
    assign rs_tracked = id_use_rs_i && (id_rs_i != '0) && busy_q[id_rs_i];
    assign rt_tracked = id_use_rt_i && (id_rt_i != '0) && busy_q[id_rt_i];
    assign rn_tracked = id_wreg_i   && (id_rn_i != '0) && busy_q[id_rn_i];

    assign raw_rs = rs_tracked && (cnt_q[id_rs_i] != '0);
    assign raw_rt = rt_tracked && (cnt_q[id_rt_i] != '0);
    assign waw    = rn_tracked && (cnt_q[id_rn_i] > lat_c);

    assign stall_o     = id_valid_i && !flush_i && (raw_rs || raw_rt || waw);
    assign issue_o     = id_valid_i && !flush_i && !stall_o;
    assign fwd_rs_o    = rs_tracked && (cnt_q[id_rs_i] == '0);
    assign fwd_rt_o    = rt_tracked && (cnt_q[id_rt_i] == '0);
    assign stall_cnt_o = stall_cnt_q;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        busy_d[0] = 1'b0;
        cnt_d[0]  = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (issue_o && id_wreg_i && (id_rn_i == AW'(r))) begin
                busy_d[r] = 1'b1;
                cnt_d[r]  = lat_c;
            end else if (wb_wreg_i && (wb_rn_i == AW'(r))) begin
                busy_d[r] = 1'b0;
                cnt_d[r]  = '0;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LW'(1);
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q      <= '0;
            stall_cnt_q <= '0;
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit; a second instance with CW=4 shares the stimulus
// so the stall counter saturation can be observed.
module tb_scoreboard_hazard_unit;

    localparam int unsigned AW = 5;
    localparam int unsigned LW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, id_valid, id_use_rs, id_use_rt, id_wreg, flush, wb_wreg;
    logic [AW-1:0] id_rs, id_rt, id_rn, wb_rn;
    logic [LW-1:0] id_lat;
    logic          stall, issue, fwd_rs, fwd_rt;
    logic [31:0]   stall_cnt;
    logic          s_stall, s_issue, s_fwd_rs, s_fwd_rt;
    logic [3:0]    s_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    scoreboard_hazard_unit #(.AW(AW), .MAXLAT(4), .LW(LW), .CW(32)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_wreg_i(id_wreg), .id_rn_i(id_rn),
        .id_lat_i(id_lat), .flush_i(flush), .wb_wreg_i(wb_wreg), .wb_rn_i(wb_rn),
        .stall_o(stall), .issue_o(issue), .fwd_rs_o(fwd_rs), .fwd_rt_o(fwd_rt),
        .stall_cnt_o(stall_cnt)
    );

    scoreboard_hazard_unit #(.AW(AW), .MAXLAT(4), .LW(LW), .CW(4)) dut_small (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_wreg_i(id_wreg), .id_rn_i(id_rn),
        .id_lat_i(id_lat), .flush_i(flush), .wb_wreg_i(wb_wreg), .wb_rn_i(wb_rn),
        .stall_o(s_stall), .issue_o(s_issue), .fwd_rs_o(s_fwd_rs), .fwd_rt_o(s_fwd_rt),
        .stall_cnt_o(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_wreg = 1'b0;
        id_rs = '0; id_rt = '0; id_rn = '0; id_lat = '0;
        flush = 1'b0; wb_wreg = 1'b0; wb_rn = '0;
    endtask

    // Present a producer (writes rn with latency lat, reads nothing).
    task automatic producer(input logic [AW-1:0] rn, input logic [LW-1:0] lat);
        idle();
        id_valid = 1'b1; id_wreg = 1'b1; id_rn = rn; id_lat = lat;
    endtask

    task automatic consumer(input logic urs, input logic [AW-1:0] rs,
                            input logic urt, input logic [AW-1:0] rt,
                            input logic wr, input logic [AW-1:0] rn);
        idle();
        id_valid = 1'b1; id_use_rs = urs; id_rs = rs; id_use_rt = urt; id_rt = rt;
        id_wreg = wr; id_rn = rn; id_lat = '0;
    endtask

    // Hold the current ID instruction: expect n stall cycles, then issue with given bypass selects.
    task automatic run_dep(input string tag, input int n, input logic efs, input logic eft);
        for (int i = 0; i < n; i++) begin
            sample();
            check({tag, "_stall"}, 32'(stall), 32'd1);
            check({tag, "_noissue"}, 32'(issue), 32'd0);
            advance();
        end
        sample();
        check({tag, "_release"}, 32'(stall), 32'd0);
        check({tag, "_issue"}, 32'(issue), 32'd1);
        check({tag, "_fwd_rs"}, 32'(fwd_rs), 32'(efs));
        check({tag, "_fwd_rt"}, 32'(fwd_rt), 32'(eft));
        advance();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;

        sample();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_issue", 32'(issue), 32'd0);
        check("rst_fwd_rs", 32'(fwd_rs), 32'd0);
        check("rst_fwd_rt", 32'(fwd_rt), 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);
        advance();

        // load r2 then add r3,r2,r4
        producer(5'd2, 3'd1);
        sample();
        check("lw_issue", 32'(issue), 32'd1);
        advance();
        consumer(1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 5'd3);
        run_dep("lw_use", 1, 1'b1, 1'b0);
        check("lw_cnt", stall_cnt, 32'd1);

        // mul r5 (lat 3) then dependent
        producer(5'd5, 3'd3);
        advance();
        consumer(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        run_dep("mul_use", 3, 1'b1, 1'b0);
        check("mul_cnt", stall_cnt, 32'd4);

        // lat 7 clamps to 4; dependent reads via rt
        producer(5'd9, 3'd7);
        advance();
        consumer(1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0);
        run_dep("clamp_use", 4, 1'b0, 1'b1);
        check("clamp_cnt", stall_cnt, 32'd8);

        // issue and writeback to r6 on the same edge: issue wins
        producer(5'd6, 3'd0);
        wb_wreg = 1'b1; wb_rn = 5'd6;
        advance();
        consumer(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
        wb_wreg = 1'b1; wb_rn = 5'd6;
        sample();
        check("wbcol_fwd", 32'(fwd_rs), 32'd1);
        check("wbcol_stall", 32'(stall), 32'd0);
        advance();
        consumer(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
        sample();
        check("wb_clear_fwd", 32'(fwd_rs), 32'd0);
        check("wb_clear_stall", 32'(stall), 32'd0);
        advance();

        // WAW on r7
        producer(5'd7, 3'd3);
        advance();
        consumer(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
        run_dep("waw", 3, 1'b0, 1'b0);
        check("waw_cnt", stall_cnt, 32'd11);

        // same sequence to r0: never tracked
        producer(5'd0, 3'd3);
        advance();
        consumer(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
        run_dep("waw_r0", 0, 1'b0, 1'b0);

        // flushed dependent on load r8; countdown continues underneath
        producer(5'd8, 3'd1);
        advance();
        consumer(1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0);
        flush = 1'b1;
        sample();
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_issue", 32'(issue), 32'd0);
        advance();
        check("flush_cnt", stall_cnt, 32'd11);
        consumer(1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0);
        run_dep("post_flush", 0, 1'b1, 1'b0);

        // flushed producer sets no entry
        producer(5'd10, 3'd3);
        flush = 1'b1;
        advance();
        consumer(1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0);
        run_dep("flush_prod", 0, 1'b0, 1'b0);

        // saturation of the CW=4 counter
        producer(5'd11, 3'd4);
        advance();
        consumer(1'b1, 5'd11, 1'b0, 5'd0, 1'b0, 5'd0);
        run_dep("sat_a", 4, 1'b1, 1'b0);
        check("sat_a_big", stall_cnt, 32'd15);
        check("sat_a_small", 32'(s_stall_cnt), 32'd15);
        producer(5'd12, 3'd4);
        advance();
        consumer(1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0);
        run_dep("sat_b", 4, 1'b1, 1'b0);
        check("sat_b_big", stall_cnt, 32'd19);
        check("sat_b_small", 32'(s_stall_cnt), 32'd15);

        // busy entries, then reset with a live producer on the inputs
        producer(5'd13, 3'd3);
        advance();
        producer(5'd14, 3'd2);
        advance();
        producer(5'd15, 3'd2);
        wb_wreg = 1'b1; wb_rn = 5'd5;
        rst = 1'b1;
        advance();
        rst = 1'b0;
        consumer(1'b1, 5'd13, 1'b1, 5'd14, 1'b0, 5'd0);
        sample();
        check("rstmid_stall", 32'(stall), 32'd0);
        check("rstmid_fwd_rs", 32'(fwd_rs), 32'd0);
        check("rstmid_fwd_rt", 32'(fwd_rt), 32'd0);
        check("rstmid_cnt", stall_cnt, 32'd0);
        check("rstmid_small_cnt", 32'(s_stall_cnt), 32'd0);
        check("rstmid_small_out", {28'd0, s_stall, s_issue, s_fwd_rs, s_fwd_rt}, 32'b0100);
        advance();
        consumer(1'b1, 5'd15, 1'b1, 5'd12, 1'b0, 5'd0);
        sample();
        check("rstmid_r15_fwd", 32'(fwd_rs), 32'd0);
        check("rstmid_r12_fwd", 32'(fwd_rt), 32'd0);
        advance();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
